// File: rtl/loop_group_scheduler_pkg.sv
// Shared types and helpers for the loop group scheduler.
package loop_sched_pkg;

  localparam int GROUP_ID_W_DEF = 2;
  localparam int QUANTUM_W_DEF  = 8;

  // Widest group id the round-robin helper can handle.
  localparam int MAX_ID_W   = 4;
  localparam int MAX_GROUPS = 1 << MAX_ID_W;

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    RUN,
    SWITCH,
    FINISH
  } sched_state_e;

  // Round-robin pick: first set bit of mask at or above ptr, wrapping at
  // num_groups (a power of two). Walking the offsets downward lets the
  // smallest offset overwrite the result last, which is the rotate /
  // priority-encode / rotate-back idiom written as a loop.
  function automatic logic [MAX_ID_W-1:0] rr_pick(
    input logic [MAX_GROUPS-1:0] mask,
    input logic [MAX_ID_W-1:0]   ptr,
    input int                    num_groups
  );
    logic [MAX_ID_W-1:0] idx;
    rr_pick = ptr;
    for (int i = MAX_GROUPS - 1; i >= 0; i--) begin
      idx = (ptr + MAX_ID_W'(i)) & MAX_ID_W'(num_groups - 1);
      if ((i < num_groups) && mask[idx]) begin
        rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rr_group_picker.sv
// Combinational round-robin grant over the pending-group mask.
module rr_group_picker
  import loop_sched_pkg::*;
#(
  parameter int GROUP_ID_W = GROUP_ID_W_DEF
) (
  input  logic [(1<<GROUP_ID_W)-1:0] mask,
  input  logic [GROUP_ID_W-1:0]      ptr,
  output logic [GROUP_ID_W-1:0]      grant,
  output logic                       any_valid
);

  localparam int NUM_GROUPS = 1 << GROUP_ID_W;

  logic [MAX_GROUPS-1:0] mask_ext;
  logic [MAX_ID_W-1:0]   ptr_ext;
  logic [MAX_ID_W-1:0]   pick;

  // Widen to the helper's fixed width, pick, then narrow back.
  always_comb begin
    mask_ext                 = '0;
    mask_ext[NUM_GROUPS-1:0] = mask;
    ptr_ext                  = '0;
    ptr_ext[GROUP_ID_W-1:0]  = ptr;
    pick                     = rr_pick(mask_ext, ptr_ext, NUM_GROUPS);
    grant                    = GROUP_ID_W'(pick);
    any_valid                = |mask;
  end

endmodule

// File: rtl/loop_group_scheduler.sv
// Time-shares one loop-nest engine among the configured loop groups.
// Optional time-slice preemption: define LOOP_SCHED_QUANTUM_EN.
//
// state  | meaning
// IDLE   | waiting for blk_start
// PICK   | choose next pending group round-robin, or finish if none
// RUN    | engine working on eng_group_id
// SWITCH | one-cycle stall bubble so the engine swaps iteration state
// FINISH | pulse blk_done, return to IDLE
module loop_group_scheduler
  import loop_sched_pkg::*;
#(
  parameter int GROUP_ID_W = GROUP_ID_W_DEF,
  parameter int QUANTUM_W  = QUANTUM_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       blk_start,
  input  logic [(1<<GROUP_ID_W)-1:0] grp_valid,
  input  logic [QUANTUM_W-1:0]       quantum,
  input  logic                       stall_in,
  input  logic                       eng_done,
  output logic                       eng_start,
  output logic [GROUP_ID_W-1:0]      eng_group_id,
  output logic                       eng_stall,
  output logic [(1<<GROUP_ID_W)-1:0] grp_done,
  output logic                       blk_done,
  output logic                       busy
);

  localparam int NUM_GROUPS = 1 << GROUP_ID_W;

  sched_state_e            state;
  logic [GROUP_ID_W-1:0]   rr_ptr;
  logic [NUM_GROUPS-1:0]   pending;
  logic [NUM_GROUPS-1:0]   started;
  logic [GROUP_ID_W-1:0]   grant;
  logic                    any_valid;

  rr_group_picker #(
    .GROUP_ID_W (GROUP_ID_W)
  ) u_picker (
    .mask      (pending),
    .ptr       (rr_ptr),
    .grant     (grant),
    .any_valid (any_valid)
  );

`ifdef LOOP_SCHED_QUANTUM_EN
  logic [QUANTUM_W-1:0]  slice_cnt;
  logic [NUM_GROUPS-1:0] others_mask;
  logic                  others_pending;
  logic                  slice_expired;

  // Preemption only makes sense when some other group is waiting.
  always_comb begin
    others_mask               = pending;
    others_mask[eng_group_id] = 1'b0;
    others_pending            = |others_mask;
    slice_expired             = (quantum != '0) &&
                                (slice_cnt == (quantum - QUANTUM_W'(1)));
  end
`else
  logic unused_quantum;
  assign unused_quantum = ^quantum;
`endif

  // Bubble is seen only in RUN/SWITCH so the engine is never stalled while idle.
  assign eng_stall = (state == SWITCH) || ((state == RUN) && stall_in);
  assign busy      = (state != IDLE);

  // Scheduler FSM with registered engine controls and completion tracking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      eng_start    <= 1'b0;
      blk_done     <= 1'b0;
      eng_group_id <= '0;
      grp_done     <= '0;
      rr_ptr       <= '0;
      pending      <= '0;
      started      <= '0;
`ifdef LOOP_SCHED_QUANTUM_EN
      slice_cnt    <= '0;
`endif
    end else begin
      eng_start <= 1'b0;
      blk_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (blk_start) begin
            pending  <= grp_valid;
            started  <= '0;
            grp_done <= '0;
            state    <= PICK;
          end
        end
        PICK: begin
          if (!any_valid) begin
            blk_done <= 1'b1;
            state    <= FINISH;
          end else begin
            eng_group_id <= grant;
            state        <= RUN;
            if (!started[grant]) begin
              eng_start      <= 1'b1;
              started[grant] <= 1'b1;
            end
`ifdef LOOP_SCHED_QUANTUM_EN
            slice_cnt <= '0;
`endif
          end
        end
        RUN: begin
          if (!stall_in) begin
            // Completion is checked first so it beats a coincident slice expiry.
            if (eng_done) begin
              pending[eng_group_id]  <= 1'b0;
              grp_done[eng_group_id] <= 1'b1;
              rr_ptr                 <= eng_group_id + GROUP_ID_W'(1);
              state                  <= SWITCH;
            end
`ifdef LOOP_SCHED_QUANTUM_EN
            else if (slice_expired && others_pending) begin
              rr_ptr <= eng_group_id + GROUP_ID_W'(1);
              state  <= SWITCH;
            end else begin
              slice_cnt <= slice_cnt + QUANTUM_W'(1);
            end
`endif
          end
        end
        SWITCH: state <= PICK;
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
